// File: rtl/bit5_booth_mul.sv
// bit5_booth_mul: sequential radix-2 Booth multiplier, 5x5 signed -> 10-bit signed product.
// Optional feature: define SIGNMAG_OUT_EN to add the sign-magnitude output product_sm.
module bit5_booth_mul (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] a_in,
   input  logic [4:0] b_in,
   output logic       busy,
   output logic       done,
   output logic [9:0] product
`ifdef SIGNMAG_OUT_EN
   ,output logic [9:0] product_sm
`endif
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t     state_q, state_d;
   logic [5:0] acc_q, acc_d, m_q, m_d, sum;
   logic [4:0] q_q, q_d;
   logic       q_m1_q, q_m1_d, busy_q, busy_d, done_q, done_d;
   logic [2:0] count_q, count_d;
   logic [9:0] product_q, product_d, prod_next;
`ifdef SIGNMAG_OUT_EN
   logic [9:0] product_sm_q, product_sm_d;
   logic [8:0] mag;
`endif
   // Booth add/subtract followed by one arithmetic shift; product is taken from the shifted pair
   always_comb begin
      sum = (q_q[0] & ~q_m1_q) ? acc_q - m_q : (~q_q[0] & q_m1_q) ? acc_q + m_q : acc_q;
      prod_next = {sum, q_q[4:1]};
      state_d = state_q;
      acc_d = acc_q;
      q_d = q_q;
      q_m1_d = q_m1_q;
      m_d = m_q;
      count_d = count_q;
      busy_d = busy_q;
      done_d = 1'b0;
      product_d = product_q;
      if (state_q == IDLE) begin
         if (start) begin
            acc_d = 6'd0;
            q_d = b_in;
            q_m1_d = 1'b0;
            m_d = {a_in[4], a_in};
            count_d = 3'd0;
            busy_d = 1'b1;
            state_d = RUN;
         end
      end else begin
         acc_d = {sum[5], sum[5:1]};
         q_d = {sum[0], q_q[4:1]};
         q_m1_d = q_q[0];
         count_d = count_q + 3'd1;
         if (count_q == 3'd4) begin
            product_d = prod_next;
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
         end
      end
   end
`ifdef SIGNMAG_OUT_EN
   // sign-magnitude view of the completing product; zero is always +0
   always_comb begin
      mag = prod_next[9] ? 9'(-prod_next) : prod_next[8:0];
      product_sm_d = (state_q == RUN && count_q == 3'd4) ? {prod_next[9], mag} : product_sm_q;
   end
`endif
   // state register; reset aborts any running operation and clears the result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q <= '0;
         q_q <= '0;
         q_m1_q <= 1'b0;
         m_q <= '0;
         count_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         product_q <= '0;
`ifdef SIGNMAG_OUT_EN
         product_sm_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         q_q <= q_d;
         q_m1_q <= q_m1_d;
         m_q <= m_d;
         count_q <= count_d;
         busy_q <= busy_d;
         done_q <= done_d;
         product_q <= product_d;
`ifdef SIGNMAG_OUT_EN
         product_sm_q <= product_sm_d;
`endif
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign product = product_q;
`ifdef SIGNMAG_OUT_EN
   assign product_sm = product_sm_q;
`endif
endmodule
